plank_fdbck_scheduler: RTL and testbench

PLANK_FDBCK_SCHEDULER -- requirements
Module: plank_fdbck_scheduler

---
 rtl/plank_fdbck_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_plank_fdbck_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plank_fdbck_scheduler.sv
// Plank feedback scheduler: polls each enabled plank in turn, streams its
// buffered feedback frame byte by byte to the shared feedback UART, then
// waits for the ACU acknowledge before moving to the next plank.
module plank_fdbck_scheduler #(
  parameter int P_NUM_PLANK = 8,
  parameter int P_FRAME_LEN = 22,
  parameter int P_TIMEOUT   = 1_000_000
) (
  input  logic                   i_clk_100,
  input  logic                   i_rst,
  input  logic                   i_poll_start,
  input  logic [P_NUM_PLANK-1:0] i_plank_mask,
  output logic [P_NUM_PLANK-1:0] o_poll_req,
  input  logic [P_NUM_PLANK-1:0] i_frame_ready,
  output logic [2:0]             o_sel,
  output logic                   o_rd_en,
  input  logic [7:0]             i_rd_data,
  input  logic                   i_rd_empty,
  output logic                   o_tx_dv,
  output logic [7:0]             o_tx_byte,
  input  logic                   i_tx_done,
  input  logic                   i_ack_rcvd,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [P_NUM_PLANK-1:0] o_timeout_mask,
  output logic [P_NUM_PLANK-1:0] o_err_mask
);

  localparam int IW = (P_NUM_PLANK > 1) ? $clog2(P_NUM_PLANK) : 1;
  localparam int TW = $clog2(P_TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, NEXT, POLL, WAIT_FRAME, READ, CAPTURE, SEND, WAIT_TX, WAIT_ACK, DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic                   exhausted, exhausted_nxt;
  logic [4:0]             byte_cnt, byte_cnt_nxt;
  logic [TW-1:0]          timer, timer_nxt;
  logic [P_NUM_PLANK-1:0] mask_q, mask_nxt;
  logic [7:0]             tx_byte_nxt;
  logic [P_NUM_PLANK-1:0] timeout_nxt, err_nxt;
  logic                   advance;
  logic [IW:0]            hit;

  // Lowest enabled plank index >= from; bit IW flags that one was found.
  function automatic logic [IW:0] find_next(input logic [P_NUM_PLANK-1:0] m,
                                            input logic [IW-1:0] from);
    find_next = '0;
    for (int i = P_NUM_PLANK - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) find_next = {1'b1, IW'(i)};
    end
  endfunction

  assign hit    = find_next(mask_q, idx);
  assign o_busy = (state != IDLE);
  assign o_sel  = 3'(idx);

  // Next-state, next-register values and strobe outputs.
  // Advancing past the last plank keeps idx saturated and sets 'exhausted',
  // so o_sel never wraps and NEXT ends the sweep instead of restarting.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    exhausted_nxt = exhausted;
    byte_cnt_nxt  = byte_cnt;
    timer_nxt     = timer;
    mask_nxt      = mask_q;
    tx_byte_nxt   = o_tx_byte;
    timeout_nxt   = o_timeout_mask;
    err_nxt       = o_err_mask;
    advance       = 1'b0;
    o_poll_req    = '0;
    o_rd_en       = 1'b0;
    o_tx_dv       = 1'b0;
    o_done        = 1'b0;

    case (state)
      IDLE: begin
        if (i_poll_start) begin
          mask_nxt      = i_plank_mask;
          idx_nxt       = '0;
          exhausted_nxt = 1'b0;
          byte_cnt_nxt  = '0;
          timeout_nxt   = '0;
          err_nxt       = '0;
          state_nxt     = NEXT;
        end
      end
      NEXT: begin
        if (!exhausted && hit[IW]) begin
          idx_nxt   = hit[IW-1:0];
          state_nxt = POLL;
        end else begin
          state_nxt = DONE;
        end
      end
      POLL: begin
        o_poll_req[idx] = 1'b1;
        timer_nxt       = TW'(P_TIMEOUT);
        state_nxt       = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        // Frame arrival wins over a simultaneous timeout.
        if (i_frame_ready[idx]) begin
          byte_cnt_nxt = '0;
          state_nxt    = READ;
        end else if (timer <= TW'(1)) begin
          timeout_nxt[idx] = 1'b1;
          advance          = 1'b1;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      READ: begin
        if (i_rd_empty) begin
          err_nxt[idx] = 1'b1;
          advance      = 1'b1;
        end else begin
          o_rd_en   = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        tx_byte_nxt = i_rd_data;
        state_nxt   = SEND;
      end
      SEND: begin
        o_tx_dv   = 1'b1;
        state_nxt = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          byte_cnt_nxt = byte_cnt + 5'd1;
          if ((byte_cnt + 5'd1) == 5'(P_FRAME_LEN)) begin
            timer_nxt = TW'(P_TIMEOUT);
            state_nxt = WAIT_ACK;
          end else begin
            state_nxt = READ;
          end
        end
      end
      WAIT_ACK: begin
        // ACK wins over a simultaneous timeout.
        if (i_ack_rcvd) begin
          advance = 1'b1;
        end else if (timer <= TW'(1)) begin
          timeout_nxt[idx] = 1'b1;
          advance          = 1'b1;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (advance) begin
      state_nxt = NEXT;
      if (idx == IW'(P_NUM_PLANK - 1)) exhausted_nxt = 1'b1;
      else                             idx_nxt       = idx + IW'(1);
    end
  end

  // State and datapath registers; reset returns everything to idle zeros.
  always_ff @(posedge i_clk_100) begin
    if (i_rst) begin
      state          <= IDLE;
      idx            <= '0;
      exhausted      <= 1'b0;
      byte_cnt       <= '0;
      timer          <= '0;
      mask_q         <= '0;
      o_tx_byte      <= '0;
      o_timeout_mask <= '0;
      o_err_mask     <= '0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      exhausted      <= exhausted_nxt;
      byte_cnt       <= byte_cnt_nxt;
      timer          <= timer_nxt;
      mask_q         <= mask_nxt;
      o_tx_byte      <= tx_byte_nxt;
      o_timeout_mask <= timeout_nxt;
      o_err_mask     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_plank_fdbck_scheduler.sv
// Scoreboard bench for plank_fdbck_scheduler: plank buffers, UART TX and ACU
// ACK are modelled by a responder; a monitor pops expected bytes/polls.
module tb_plank_fdbck_scheduler;

  localparam int NP     = 8;
  localparam int FL     = 22;
  localparam int TMO    = 500;
  localparam int TX_LAT = 100;
  localparam int ACK_LAT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_rst, i_poll_start, i_rd_empty, i_tx_done, i_ack_rcvd;
  logic [NP-1:0] i_plank_mask, i_frame_ready;
  logic [7:0]    i_rd_data;
  logic [NP-1:0] o_poll_req, o_timeout_mask, o_err_mask;
  logic [2:0]    o_sel;
  logic          o_rd_en, o_tx_dv, o_busy, o_done;
  logic [7:0]    o_tx_byte;

  plank_fdbck_scheduler #(
    .P_NUM_PLANK(NP), .P_FRAME_LEN(FL), .P_TIMEOUT(TMO)
  ) dut (
    .i_clk_100(clk), .i_rst(i_rst), .i_poll_start(i_poll_start),
    .i_plank_mask(i_plank_mask), .o_poll_req(o_poll_req),
    .i_frame_ready(i_frame_ready), .o_sel(o_sel), .o_rd_en(o_rd_en),
    .i_rd_data(i_rd_data), .i_rd_empty(i_rd_empty), .o_tx_dv(o_tx_dv),
    .o_tx_byte(o_tx_byte), .i_tx_done(i_tx_done), .i_ack_rcvd(i_ack_rcvd),
    .o_busy(o_busy), .o_done(o_done), .o_timeout_mask(o_timeout_mask),
    .o_err_mask(o_err_mask)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]    buf_mem [NP][32];
  int            buf_len [NP];
  int            rd_ptr  [NP];
  logic [7:0]    exp_q[$];
  logic [NP-1:0] poll_q[$];

  int dv_cnt = 0, done_cnt = 0, done_cyc = 0, last_dv_cyc = 0;
  int poll2_cyc = -1, tmo_cyc = -1, start_cyc = 0;
  int tx_timer = 0, ack_timer = 0, frame_bytes = 0;
  bit rd_pend = 0;
  logic [2:0] sel_pend = '0;
  bit ack_en = 1;

  assign i_rd_empty = (rd_ptr[o_sel] >= buf_len[o_sel]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Responder: buffer reads, TX completion after TX_LAT, ACK after a full frame.
  initial forever begin
    @(negedge clk);
    i_tx_done  = 1'b0;
    i_ack_rcvd = 1'b0;
    if (i_rst) begin
      tx_timer = 0; ack_timer = 0; frame_bytes = 0; rd_pend = 0;
    end else begin
      if (rd_pend) begin
        rd_ptr[sel_pend]++;
        rd_pend = 0;
      end
      if (o_rd_en) begin
        i_rd_data = buf_mem[o_sel][rd_ptr[o_sel]];
        sel_pend  = o_sel;
        rd_pend   = 1;
      end
      if (o_poll_req != '0) frame_bytes = 0;
      if (tx_timer > 0) begin
        tx_timer--;
        if (tx_timer == 0) begin
          i_tx_done = 1'b1;
          frame_bytes++;
          if (frame_bytes == FL && ack_en) ack_timer = ACK_LAT;
        end
      end
      if (o_tx_dv) tx_timer = TX_LAT;
      if (ack_timer > 0) begin
        ack_timer--;
        if (ack_timer == 0) i_ack_rcvd = 1'b1;
      end
    end
  end

  // Monitor: compares every tx byte and poll request against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!i_rst) begin
      if (o_tx_dv) begin
        dv_cnt++;
        last_dv_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got byte 0x%0h with no byte expected", o_tx_byte);
        end else begin
          check("tx_byte", 32'(o_tx_byte), 32'(exp_q.pop_front()));
        end
      end
      if (o_poll_req != '0) begin
        if (o_poll_req == 8'h04) poll2_cyc = cyc;
        if (poll_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL poll_unexpected: got poll 0x%0h with no poll expected", o_poll_req);
        end else begin
          check("poll_req", 32'(o_poll_req), 32'(poll_q.pop_front()));
        end
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_timeout_mask != '0 && tmo_cyc < 0) tmo_cyc = cyc;
    end
  end

  task automatic clear_bufs();
    for (int p = 0; p < NP; p++) begin
      buf_len[p] = 0;
      rd_ptr[p]  = 0;
    end
    exp_q.delete();
    poll_q.delete();
  endtask

  // Frame: AA, E2+p, 17 x 32, 00, D0^p, 55; only the first n bytes are buffered.
  task automatic load_frame(input int p, input int n);
    logic [7:0] b;
    for (int k = 0; k < FL; k++) begin
      if (k == 0)       b = 8'hAA;
      else if (k == 1)  b = 8'hE2 + 8'(p);
      else if (k <= 18) b = 8'h32;
      else if (k == 19) b = 8'h00;
      else if (k == 20) b = 8'hD0 ^ 8'(p);
      else              b = 8'h55;
      buf_mem[p][k] = b;
      if (k < n) exp_q.push_back(b);
    end
    buf_len[p] = n;
    rd_ptr[p]  = 0;
  endtask

  task automatic run_sweep(input logic [NP-1:0] mask, input int budget, input string name);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 0;
    i_plank_mask = mask;
    @(negedge clk);
    i_poll_start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    i_poll_start = 1'b0;
    i_plank_mask = ~mask;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk);
      if (done_cnt != d0) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_done_wait: got no o_done within %0d cycles, required one", name, budget);
    end
    repeat (5) @(negedge clk);
  endtask

  int dv0, dn0;

  initial begin
    i_rst = 1'b1; i_poll_start = 1'b0; i_plank_mask = '0; i_frame_ready = '0;
    i_rd_data = '0; i_tx_done = 1'b0; i_ack_rcvd = 1'b0;
    clear_bufs();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_poll", 32'(o_poll_req), 0);
    check("rst_sel", 32'(o_sel), 0);
    check("rst_rd_en", 32'(o_rd_en), 0);
    check("rst_tx_dv", 32'(o_tx_dv), 0);
    check("rst_tx_byte", 32'(o_tx_byte), 0);
    check("rst_tmo_mask", 32'(o_timeout_mask), 0);
    check("rst_err_mask", 32'(o_err_mask), 0);
    i_rst = 1'b0;
    @(negedge clk);

    // Single plank, full frame, ACKed.
    clear_bufs(); load_frame(0, FL); poll_q.push_back(8'h01);
    i_frame_ready = 8'h01; dv0 = dv_cnt; dn0 = done_cnt;
    run_sweep(8'h01, 4000, "t1");
    check("t1_dv_count", 32'(dv_cnt - dv0), FL);
    check("t1_done_count", 32'(done_cnt - dn0), 1);
    check("t1_tmo_mask", 32'(o_timeout_mask), 0);
    check("t1_err_mask", 32'(o_err_mask), 0);
    check("t1_bytes_left", 32'(exp_q.size()), 0);

    // Plank 2 never ready: frame timeout after plank 0 completes.
    clear_bufs(); load_frame(0, FL); poll_q.push_back(8'h01); poll_q.push_back(8'h04);
    i_frame_ready = 8'h01; dv0 = dv_cnt; dn0 = done_cnt; tmo_cyc = -1; poll2_cyc = -1;
    run_sweep(8'h05, 5000, "t2");
    check("t2_dv_count", 32'(dv_cnt - dv0), FL);
    check("t2_done_count", 32'(done_cnt - dn0), 1);
    check("t2_tmo_mask", 32'(o_timeout_mask), 32'h04);
    check("t2_err_mask", 32'(o_err_mask), 0);
    // Timer expires in the P_TIMEOUT-th wait cycle; the flag shows the cycle after.
    check("t2_tmo_latency", 32'(tmo_cyc - poll2_cyc), 32'(TMO + 1));
    check("t2_polls_left", 32'(poll_q.size()), 0);

    // Plank 7 buffer runs dry after 10 bytes: short-frame error, no ACK wait.
    clear_bufs(); load_frame(7, 10); poll_q.push_back(8'h80);
    i_frame_ready = 8'h80; dv0 = dv_cnt; dn0 = done_cnt;
    run_sweep(8'h80, 3000, "t3");
    check("t3_dv_count", 32'(dv_cnt - dv0), 10);
    check("t3_done_count", 32'(done_cnt - dn0), 1);
    check("t3_err_mask", 32'(o_err_mask), 32'h80);
    check("t3_tmo_mask", 32'(o_timeout_mask), 0);
    check("t3_done_after_last_dv", 32'(done_cyc - last_dv_cyc), 32'(TX_LAT + 3));

    // All planks, mid-sweep start pulses must be ignored.
    clear_bufs();
    for (int p = 0; p < NP; p++) begin
      load_frame(p, FL);
      poll_q.push_back(NP'(1) << p);
    end
    i_frame_ready = 8'hFF; dv0 = dv_cnt; dn0 = done_cnt;
    fork
      begin
        repeat (3) begin
          repeat (700) @(negedge clk);
          i_poll_start = 1'b1;
          @(negedge clk);
          i_poll_start = 1'b0;
        end
      end
    join_none
    run_sweep(8'hFF, 25000, "t4");
    check("t4_dv_count", 32'(dv_cnt - dv0), 32'(NP * FL));
    check("t4_done_count", 32'(done_cnt - dn0), 1);
    check("t4_tmo_mask", 32'(o_timeout_mask), 0);
    check("t4_err_mask", 32'(o_err_mask), 0);
    check("t4_polls_left", 32'(poll_q.size()), 0);

    // Reset while waiting on TX of byte 5, then a fresh sweep.
    clear_bufs(); load_frame(0, FL); poll_q.push_back(8'h01);
    i_frame_ready = 8'h01; dv0 = dv_cnt;
    i_plank_mask = 8'h01;
    @(negedge clk); i_poll_start = 1'b1;
    @(negedge clk); i_poll_start = 1'b0;
    for (int n = 0; n < 2000 && (dv_cnt - dv0) < 5; n++) @(negedge clk);
    check("t5_dv_before_rst", 32'(dv_cnt - dv0), 5);
    repeat (2) @(negedge clk);
    i_rst = 1'b1;
    tx_timer = 0; ack_timer = 0; frame_bytes = 0; rd_pend = 0;
    @(negedge clk);
    check("t5_busy", 32'(o_busy), 0);
    check("t5_tx_byte", 32'(o_tx_byte), 0);
    check("t5_sel", 32'(o_sel), 0);
    check("t5_strobes", 32'({o_tx_dv, o_rd_en, o_done}), 0);
    check("t5_poll", 32'(o_poll_req), 0);
    check("t5_masks", 32'({o_timeout_mask, o_err_mask}), 0);
    i_rst = 1'b0;
    clear_bufs(); load_frame(0, FL); poll_q.push_back(8'h01);
    dv0 = dv_cnt; dn0 = done_cnt;
    run_sweep(8'h01, 4000, "t5");
    check("t5_dv_count", 32'(dv_cnt - dv0), FL);
    check("t5_done_count", 32'(done_cnt - dn0), 1);

    // Empty mask: done two cycles after the start pulse, no activity.
    clear_bufs(); i_frame_ready = 8'hFF; dv0 = dv_cnt; dn0 = done_cnt;
    run_sweep(8'h00, 50, "t6");
    check("t6_done_latency", 32'(done_cyc - start_cyc), 2);
    check("t6_done_count", 32'(done_cnt - dn0), 1);
    check("t6_dv_count", 32'(dv_cnt - dv0), 0);
    check("t6_masks", 32'({o_timeout_mask, o_err_mask}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
